// File: rtl/requant_unit.sv
// -----------------------------------------------------------------------------
// requant_unit
//
// Requantizes each signed dot-product sum (sum_all) into a signed output byte
// (compress) through three pipeline stages:
//   S1  acc  = sum_all + bias                  (IN_W+1 bits, cannot overflow)
//   S2  prod = acc * scale                     (scale is unsigned, product exact)
//   S3  r    = round-half-up(prod >>> shift), optional ReLU, clamp to OUT_W
//
// All three stages advance together whenever the output register is empty or
// being drained (en = ~out_valid | out_ready). Bubbles travel with the data,
// so an accepted beat always appears at the output three enabled cycles later.
// The configuration registers may only change while the pipeline is empty.
// Because of that, every stage can read them directly without per-beat copies.
//
// Ports
//   clk, rst        single rising-edge clock, synchronous active-high reset
//   cfg_we          load cfg_bias/scale/shift/relu (only when idle, no input)
//   cfg_bias        signed bias added to sum_all
//   cfg_scale       unsigned multiplier
//   cfg_shift       arithmetic right shift 0..31 with round half toward +inf
//   cfg_relu        1: negative results become 0
//   cfg_err         one-cycle pulse after a cfg_we that was ignored
//   in_valid/ready  input handshake for sum_all
//   out_valid/ready output handshake for compress
//   busy            some stage holds a valid beat
//   sat_cnt         saturated beats delivered at the output, sticks at all-ones
// -----------------------------------------------------------------------------
module requant_unit #(
   parameter int IN_W    = 21,
   parameter int SCALE_W = 16,
   parameter int SHIFT_W = 5,
   parameter int OUT_W   = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_we,
   input  logic signed [IN_W-1:0]    cfg_bias,
   input  logic [SCALE_W-1:0]        cfg_scale,
   input  logic [SHIFT_W-1:0]        cfg_shift,
   input  logic                      cfg_relu,
   output logic                      cfg_err,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [IN_W-1:0]    sum_all,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [OUT_W-1:0]   compress,
   output logic                      busy,
   output logic [15:0]               sat_cnt
);

   // Sum of two IN_W signed values needs one extra bit.
   localparam int ACC_W  = IN_W + 1;
   // Signed acc times unsigned scale (zero-extended to SCALE_W+1 signed).
   localparam int PROD_W = ACC_W + SCALE_W + 1;
   // One guard bit so adding the rounding half can never wrap.
   localparam int RND_W  = PROD_W + 1;

   localparam logic signed [OUT_W-1:0] OUT_MAX_B = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] OUT_MIN_B = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic signed [RND_W-1:0] OUT_MAX_R = RND_W'(OUT_MAX_B);
   localparam logic signed [RND_W-1:0] OUT_MIN_R = RND_W'(OUT_MIN_B);

   localparam logic [15:0] SAT_CNT_MAX = 16'hFFFF;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   // Configuration
   logic signed [IN_W-1:0]    cfg_bias_q,  cfg_bias_d;
   logic [SCALE_W-1:0]        cfg_scale_q, cfg_scale_d;
   logic [SHIFT_W-1:0]        cfg_shift_q, cfg_shift_d;
   logic                      cfg_relu_q,  cfg_relu_d;
   logic                      cfg_err_q,   cfg_err_d;

   // Pipeline control
   logic                      s1_valid_q,  s1_valid_d;
   logic                      s2_valid_q,  s2_valid_d;
   logic                      out_valid_q, out_valid_d;

   // Pipeline data
   logic signed [ACC_W-1:0]   s1_acc_q,    s1_acc_d;
   logic signed [PROD_W-1:0]  s2_prod_q,   s2_prod_d;
   logic signed [OUT_W-1:0]   compress_q,  compress_d;
   logic                      out_sat_q,   out_sat_d;

   logic [15:0]               sat_cnt_q,   sat_cnt_d;

   // ---------------------------------------------------------------------------
   // Handshake and configuration control
   // ---------------------------------------------------------------------------
   logic en;
   logic in_accept;
   logic out_accept;
   logic busy_c;
   logic cfg_load;

   always_comb begin
      en         = ~out_valid_q | out_ready;
      in_accept  = in_valid & en;
      out_accept = out_valid_q & out_ready;
      busy_c     = s1_valid_q | s2_valid_q | out_valid_q;
      // A write is taken only when nothing is in flight and no beat is being
      // presented; when idle in_ready is 1, so in_valid alone means an accept.
      cfg_load   = cfg_we & ~busy_c & ~in_valid;
   end

   // ---------------------------------------------------------------------------
   // Arithmetic
   // ---------------------------------------------------------------------------
   logic signed [ACC_W-1:0]   acc_c;
   logic signed [PROD_W-1:0]  prod_c;
   logic signed [RND_W-1:0]   rnd_in;
   logic signed [RND_W-1:0]   rnd_half;
   logic signed [RND_W-1:0]   rnd_sum;
   logic signed [RND_W-1:0]   rnd_r;
   logic signed [RND_W-1:0]   relu_r;
   logic signed [OUT_W-1:0]   res_c;
   logic                      sat_c;

   // NOTE: combinational blocks use blocking '=' so later statements see the
   // values computed above them within the same evaluation.
   always_comb begin
      // S1: signed size casts sign-extend both operands.
      acc_c  = ACC_W'(sum_all) + ACC_W'(cfg_bias_q);

      // S2: scale is unsigned, so it enters the signed multiply zero-extended.
      prod_c = PROD_W'(s1_acc_q) * PROD_W'($signed({1'b0, cfg_scale_q}));

      // S3: add half an LSB of the result before the arithmetic shift, which
      // rounds ties toward +inf; shift 0 passes the product through.
      rnd_in   = RND_W'(s2_prod_q);
      rnd_half = '0;
      rnd_sum  = rnd_in;
      rnd_r    = rnd_in;
      if (cfg_shift_q != '0) begin
         rnd_half = RND_W'(1) << (cfg_shift_q - SHIFT_W'(1));
         rnd_sum  = rnd_in + rnd_half;
         rnd_r    = rnd_sum >>> cfg_shift_q;
      end

      // ReLU zeroes negatives before the clamp, so it never counts as a saturation.
      relu_r = rnd_r;
      if (cfg_relu_q && (rnd_r < 0)) begin
         relu_r = '0;
      end

      sat_c = 1'b0;
      res_c = relu_r[OUT_W-1:0];
      if (relu_r > OUT_MAX_R) begin
         res_c = OUT_MAX_B;
         sat_c = 1'b1;
      end else if (relu_r < OUT_MIN_R) begin
         res_c = OUT_MIN_B;
         sat_c = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Next state
   // ---------------------------------------------------------------------------
   // NOTE: every _d gets its hold value first, so no path through this block
   // leaves a signal unassigned and no latch can be inferred.
   always_comb begin
      cfg_bias_d  = cfg_bias_q;
      cfg_scale_d = cfg_scale_q;
      cfg_shift_d = cfg_shift_q;
      cfg_relu_d  = cfg_relu_q;
      cfg_err_d   = 1'b0;

      s1_valid_d  = s1_valid_q;
      s2_valid_d  = s2_valid_q;
      out_valid_d = out_valid_q;
      s1_acc_d    = s1_acc_q;
      s2_prod_d   = s2_prod_q;
      compress_d  = compress_q;
      out_sat_d   = out_sat_q;
      sat_cnt_d   = sat_cnt_q;

      if (cfg_load) begin
         cfg_bias_d  = cfg_bias;
         cfg_scale_d = cfg_scale;
         cfg_shift_d = cfg_shift;
         cfg_relu_d  = cfg_relu;
      end else if (cfg_we) begin
         cfg_err_d = 1'b1;
      end

      // All stages move in lockstep; an empty slot moves as a bubble.
      if (en) begin
         s1_valid_d  = in_accept;
         s1_acc_d    = acc_c;
         s2_valid_d  = s1_valid_q;
         s2_prod_d   = prod_c;
         out_valid_d = s2_valid_q;
         // Only real beats overwrite compress, so it keeps its last value
         // across bubbles instead of showing unrelated arithmetic.
         if (s2_valid_q) begin
            compress_d = res_c;
            out_sat_d  = sat_c;
         end
      end

      if (out_accept && out_sat_q && (sat_cnt_q != SAT_CNT_MAX)) begin
         sat_cnt_d = sat_cnt_q + 16'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential blocks use non-blocking '<=' so every flop samples the
   // pre-edge value of every other flop regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_bias_q  <= '0;
         cfg_scale_q <= SCALE_W'(1);
         cfg_shift_q <= '0;
         cfg_relu_q  <= 1'b0;
         cfg_err_q   <= 1'b0;
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         compress_q  <= '0;
         sat_cnt_q   <= '0;
      end else begin
         cfg_bias_q  <= cfg_bias_d;
         cfg_scale_q <= cfg_scale_d;
         cfg_shift_q <= cfg_shift_d;
         cfg_relu_q  <= cfg_relu_d;
         cfg_err_q   <= cfg_err_d;
         s1_valid_q  <= s1_valid_d;
         s2_valid_q  <= s2_valid_d;
         out_valid_q <= out_valid_d;
         compress_q  <= compress_d;
         sat_cnt_q   <= sat_cnt_d;
      end
   end

   // NOTE: intermediate data flops carry no reset; their contents are only
   // ever observed together with a valid bit, and the valid bits are reset.
   always_ff @(posedge clk) begin
      s1_acc_q  <= s1_acc_d;
      s2_prod_q <= s2_prod_d;
      out_sat_q <= out_sat_d;
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign in_ready  = en;
   assign out_valid = out_valid_q;
   assign compress  = compress_q;
   assign busy      = busy_c;
   assign sat_cnt   = sat_cnt_q;
   assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_requant_unit.sv
// -----------------------------------------------------------------------------
// tb_requant_unit
//
// Directed bench for requant_unit. Each beat driven into the unit pushes its
// expected byte and saturation flag onto a scoreboard queue; a monitor pops
// and compares whenever a beat leaves the output, and also watches that a
// stalled output stays frozen with in_ready low. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_requant_unit;

   typedef struct packed {
      logic [7:0] data;
      logic       sat;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        cfg_we;
   logic [20:0] cfg_bias;
   logic [15:0] cfg_scale;
   logic [4:0]  cfg_shift;
   logic        cfg_relu;
   logic        cfg_err;
   logic        in_valid;
   logic        in_ready;
   logic [20:0] sum_all;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  compress;
   logic        busy;
   logic [15:0] sat_cnt;

   int          n_tests;
   int          n_fail;
   exp_t        sb[$];
   logic [15:0] exp_sat;

   // Shadow of the configuration the unit is expected to be using.
   longint      m_bias;
   longint      m_scale;
   int          m_shift;
   bit          m_relu;

   logic        have_hold;
   logic [7:0]  hold_val;

   requant_unit dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_bias  (cfg_bias),
      .cfg_scale (cfg_scale),
      .cfg_shift (cfg_shift),
      .cfg_relu  (cfg_relu),
      .cfg_err   (cfg_err),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum_all   (sum_all),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .compress  (compress),
      .busy      (busy),
      .sat_cnt   (sat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference arithmetic on 64-bit integers.
   task automatic model(input longint s, output logic [7:0] b, output logic sat);
      longint acc;
      longint prod;
      longint r;
      acc  = s + m_bias;
      prod = acc * m_scale;
      if (m_shift == 0) r = prod;
      else              r = (prod + (longint'(1) << (m_shift - 1))) >>> m_shift;
      if (m_relu && r < 0) r = 0;
      sat = 1'b0;
      if (r > 127) begin
         r = 127;
         sat = 1'b1;
      end else if (r < -128) begin
         r = -128;
         sat = 1'b1;
      end
      b = r[7:0];
   endtask

   // Presents one beat until accepted; leaves at 1 unit past the accepting edge.
   task automatic send(input int v, input logic [7:0] eb, input logic es);
      logic acc_ok;
      exp_t e;
      in_valid = 1'b1;
      sum_all  = 21'(v);
      e.data   = eb;
      e.sat    = es;
      sb.push_back(e);
      acc_ok = 1'b0;
      for (int n = 0; n < 100 && !acc_ok; n++) begin
         @(negedge clk);
         acc_ok = in_ready;
         tick();
      end
      in_valid = 1'b0;
      check("accept", {31'd0, acc_ok}, 32'd1);
   endtask

   task automatic send_m(input int v);
      logic [7:0] b;
      logic       s;
      model(longint'(v), b, s);
      send(v, b, s);
   endtask

   // Waits until every expected beat has been delivered and the unit is idle.
   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || busy) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_queue", sb.size(), 0);
      check("drain_idle", {31'd0, busy}, 32'd0);
      tick();
   endtask

   // Loads a configuration while idle and confirms it was not rejected.
   task automatic cfg_set(input int b, input int sc, input int sh, input bit r);
      cfg_bias  = 21'(b);
      cfg_scale = 16'(sc);
      cfg_shift = 5'(sh);
      cfg_relu  = r;
      cfg_we    = 1'b1;
      tick();
      cfg_we    = 1'b0;
      m_bias    = longint'(b);
      m_scale   = longint'(sc);
      m_shift   = sh;
      m_relu    = r;
      @(negedge clk);
      check("cfg_err_on_load", {31'd0, cfg_err}, 32'd0);
      tick();
   endtask

   // Output monitor: scoreboard compare and stall stability.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         have_hold = 1'b0;
      end else begin
         if (have_hold) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_stable", {24'd0, compress}, {24'd0, hold_val});
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("stale_beat", {31'd0, out_valid}, 32'd0);
            end else begin
               e = sb.pop_front();
               check("compress", {24'd0, compress}, {24'd0, e.data});
               if (e.sat && exp_sat != 16'hFFFF) exp_sat = exp_sat + 16'd1;
            end
         end
         if (out_valid && !out_ready) begin
            check("in_ready_stall", {31'd0, in_ready}, 32'd0);
            have_hold = 1'b1;
            hold_val  = compress;
         end else begin
            have_hold = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int vals[8];
      int idx;
      int cyc;
      logic [7:0] b;
      logic       s;
      exp_t       e;

      vals = '{0, 1, -1, 100, -100, 300, -300, 12345};
      n_tests   = 0;
      n_fail    = 0;
      exp_sat   = '0;
      have_hold = 1'b0;
      hold_val  = '0;
      m_bias = 0; m_scale = 1; m_shift = 0; m_relu = 1'b0;

      rst       = 1'b1;
      cfg_we    = 1'b0;
      cfg_bias  = '0;
      cfg_scale = '0;
      cfg_shift = '0;
      cfg_relu  = 1'b0;
      in_valid  = 1'b0;
      sum_all   = '0;
      out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_compress", {24'd0, compress}, 32'd0);
      check("rst_sat_cnt", {16'd0, sat_cnt}, 32'd0);
      check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      tick();

      // T1: default config is identity with saturation; latency of 3 cycles.
      in_valid = 1'b1;
      sum_all  = 21'(100);
      e.data = 8'd100;
      e.sat  = 1'b0;
      sb.push_back(e);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("lat_cycle1", {31'd0, out_valid}, 32'd0);
      tick();
      @(negedge clk);
      check("lat_cycle2", {31'd0, out_valid}, 32'd0);
      tick();
      @(negedge clk);
      check("lat_cycle3", {31'd0, out_valid}, 32'd1);
      check("lat_data", {24'd0, compress}, 32'd100);
      tick();
      drain();
      send(300, 8'h7F, 1'b1);
      drain();
      check("t1_sat_cnt", {16'd0, sat_cnt}, 32'd1);

      // T2: bias/scale/shift with round half toward +inf.
      cfg_set(-50, 3, 2, 1'b0);
      send(10, 8'hE2, 1'b0);
      send(11, 8'hE3, 1'b0);
      drain();
      check("t2_sat_cnt", {16'd0, sat_cnt}, 32'd1);

      // T3: ReLU zeroes negatives without counting a saturation.
      cfg_set(0, 1, 0, 1'b1);
      send(-500, 8'h00, 1'b0);
      send(1000, 8'h7F, 1'b1);
      drain();
      check("t3_sat_cnt", {16'd0, sat_cnt}, 32'd2);

      // T4: extreme operands.
      cfg_set(-1048576, 65535, 31, 1'b0);
      send(-1048576, 8'hC0, 1'b0);
      drain();
      check("t4_sat_cnt", {16'd0, sat_cnt}, 32'd2);

      // T5: back-to-back stream with a 4-cycle output stall.
      cfg_set(7, 5, 3, 1'b0);
      idx = 0;
      cyc = 0;
      while (idx < 8 && cyc < 100) begin
         out_ready = !(cyc >= 4 && cyc < 8);
         in_valid  = 1'b1;
         sum_all   = 21'(vals[idx]);
         @(negedge clk);
         if (in_ready) begin
            model(longint'(vals[idx]), b, s);
            e.data = b;
            e.sat  = s;
            sb.push_back(e);
            idx++;
         end
         tick();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("t5_all_sent", idx, 32'd8);
      drain();
      check("t5_sat_cnt", {16'd0, sat_cnt}, {16'd0, exp_sat});

      // T6a: cfg write while busy is ignored and flagged for one cycle.
      send_m(20);
      cfg_bias  = 21'(999);
      cfg_scale = 16'd100;
      cfg_shift = 5'd0;
      cfg_relu  = 1'b0;
      cfg_we    = 1'b1;
      tick();
      cfg_we = 1'b0;
      @(negedge clk);
      check("cfg_err_busy", {31'd0, cfg_err}, 32'd1);
      tick();
      @(negedge clk);
      check("cfg_err_pulse_end", {31'd0, cfg_err}, 32'd0);
      tick();
      drain();
      send_m(20);
      drain();

      // T6b: cfg write together with an accepted beat is ignored as well.
      cfg_we   = 1'b1;
      in_valid = 1'b1;
      sum_all  = 21'(40);
      model(64'sd40, b, s);
      e.data = b;
      e.sat  = s;
      sb.push_back(e);
      tick();
      cfg_we   = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("cfg_err_with_beat", {31'd0, cfg_err}, 32'd1);
      tick();
      drain();
      send_m(40);
      drain();

      // T6c: reset mid-stream drops in-flight beats and restores defaults.
      send_m(1);
      send_m(2);
      send_m(3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      exp_sat = '0;
      m_bias = 0; m_scale = 1; m_shift = 0; m_relu = 1'b0;
      @(negedge clk);
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_sat_cnt", {16'd0, sat_cnt}, 32'd0);
      tick();
      repeat (8) tick();
      send_m(100);
      drain();
      check("final_sat_cnt", {16'd0, sat_cnt}, {16'd0, exp_sat});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
